// File: rtl/inv_key_scheduler.sv
// inv_key_scheduler
//   Walks an AES-128 key schedule backwards. It starts from the round-Nr key
//   and emits keys for rounds Nr, Nr-1, ... 0 over a valid/ready handshake.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request; loads last_key. Ignored while busy.
//   last_key     round-Nr key, bit 0 = MSB, word 0 = bits 0..31
//   abort        synchronous cancel. Beats start and any transfer.
//   key_out      current round key
//   round_idx    round number of key_out
//   key_valid    key_out/round_idx are valid
//   key_ready    consumer accepts key_out
//   busy         the FSM is not in IDLE
//   done         one-cycle pulse after the round-0 key transfer
//
// Configuration
//   INV_KEY_SBOX_REG_EN  When defined, the SubWord result is registered.
//                        Each step then spends one cycle in STEP with
//                        key_valid=0, so the block emits one key every two
//                        cycles. Key values are the same in both builds.
module inv_key_scheduler #(
    parameter int Nr = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] last_key,
    input  logic         abort,
    output logic [0:127] key_out,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

`ifdef INV_KEY_SBOX_REG_EN
    typedef enum logic [1:0] {IDLE, EMIT, DONE, STEP} stateT;
`else
    typedef enum logic [1:0] {IDLE, EMIT, DONE} stateT;
`endif

    // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box built from the field inverse (x^254, which maps 0 to 0) and the
    // affine transform. This replaces a 256-entry ROM.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] expo;
        inv  = 8'h01;
        expo = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            inv = gfMul(inv, inv);
            if (expo[i]) inv = gfMul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubWord(RotWord(w))
    function automatic logic [31:0] subRot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    stateT        state, stateNext;
    logic [0:127] keyReg, keyNext;
    logic [3:0]   roundReg, roundNext;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p1, p2, p3;
    logic [31:0] rconWord;

    assign w0 = keyReg[0:31];
    assign w1 = keyReg[32:63];
    assign w2 = keyReg[64:95];
    assign w3 = keyReg[96:127];

    // Words 1..3 of the previous round key fall out of simple XORs. Word 0
    // also needs SubWord of the new word 3.
    assign p3       = w3 ^ w2;
    assign p2       = w2 ^ w1;
    assign p1       = w1 ^ w0;
    assign rconWord = {rcon(roundReg), 24'h000000};

`ifdef INV_KEY_SBOX_REG_EN
    logic [31:0] subReg, subNext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            keyReg   <= '0;
            roundReg <= '0;
`ifdef INV_KEY_SBOX_REG_EN
            subReg   <= '0;
`endif
        end else begin
            state    <= stateNext;
            keyReg   <= keyNext;
            roundReg <= roundNext;
`ifdef INV_KEY_SBOX_REG_EN
            subReg   <= subNext;
`endif
        end
    end

    always_comb begin
        stateNext = state;
        keyNext   = keyReg;
        roundNext = roundReg;
`ifdef INV_KEY_SBOX_REG_EN
        subNext   = subReg;
`endif
        if (abort) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        keyNext   = last_key;
                        roundNext = 4'(Nr);
                        stateNext = EMIT;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        if (roundReg != 4'd0) begin
`ifdef INV_KEY_SBOX_REG_EN
                            subNext   = subRot(p3);
                            stateNext = STEP;
`else
                            keyNext   = {w0 ^ subRot(p3) ^ rconWord, p1, p2, p3};
                            roundNext = roundReg - 4'd1;
`endif
                        end else begin
                            stateNext = DONE;
                        end
                    end
                end
                DONE: stateNext = IDLE;
`ifdef INV_KEY_SBOX_REG_EN
                STEP: begin
                    // keyReg still holds the round-r key here, so w0/p* and
                    // rconWord still refer to round r.
                    keyNext   = {w0 ^ subReg ^ rconWord, p1, p2, p3};
                    roundNext = roundReg - 4'd1;
                    stateNext = EMIT;
                end
`endif
                default: stateNext = IDLE;
            endcase
        end
    end

    assign key_out   = keyReg;
    assign round_idx = roundReg;
    assign key_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
